// File: rtl/vdg_pkg.sv
// Shared constants, mode/state enums and byte context for the VDG pixel serializer.
// VDG_SEMIGRAPHICS_EN selects whether selSemi decodes to a separate SEMI mode.
package vdg_pkg;

  localparam int         PIXELS_PER_BYTE = 8;
  localparam logic [3:0] SEMI_SPLIT_ROW  = 4'd6;
  localparam logic [2:0] COL_BASE        = 3'd0;
  localparam logic [2:0] COL_ALT         = 3'd5;

  typedef enum logic [1:0] {
    MODE_ALPHA,
    MODE_SEMI,
    MODE_GRAPH
  } vdgMode_t;

  typedef enum logic {
    ST_EMPTY,
    ST_SHIFT
  } shiftState_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] row;
    logic       css;
    vdgMode_t   mode;
    logic       div;
  } byteCtx_t;

  function automatic vdgMode_t decodeMode(input logic selAlpha, input logic selSemi);
`ifdef VDG_SEMIGRAPHICS_EN
    if (selSemi)  return MODE_SEMI;
    if (selAlpha) return MODE_ALPHA;
`else
    if (selAlpha || selSemi) return MODE_ALPHA;
`endif
    return MODE_GRAPH;
  endfunction

endpackage

// File: rtl/semi_quad_decode.sv
// Picks the semigraphic quadrant bit for a pixel slot from the cell row and slot half.
// Only instantiated when VDG_SEMIGRAPHICS_EN is defined.
module semi_quad_decode
  import vdg_pkg::*;
(
  input  logic [3:0] quad,
  input  logic [3:0] row,
  input  logic [2:0] slot,
  output logic       quadBit
);

  logic topHalf;
  logic rightHalf;

  assign topHalf   = row < SEMI_SPLIT_ROW;
  assign rightHalf = slot[2];
  assign quadBit   = topHalf ? (rightHalf ? quad[2] : quad[3])
                             : (rightHalf ? quad[0] : quad[1]);

endmodule

// File: rtl/vdg_pixel_serializer.sv
// Byte-to-pixel serializer with a one-byte holding register and REQ/LOAD handshake.
// Semigraphics decode is compiled only when VDG_SEMIGRAPHICS_EN is defined.
//
// state    | meaning
// ST_EMPTY | no byte in the shifter, outputs idle
// ST_SHIFT | shifting 8 pixel slots (1 or 2 clocks each)
module vdg_pixel_serializer
  import vdg_pkg::*;
(
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       LOAD,
  input  logic [7:0] DD,
  input  logic [3:0] ROW,
  input  logic       CSS,
  input  logic       selAlpha,
  input  logic       selSemi,
  input  logic       Divider,
  output logic       REQ,
  output logic       PIX_VALID,
  output logic       PIX_ON,
  output logic [2:0] PIX_COL,
  output logic       UNDERRUN
);

  shiftState_t state;
  byteCtx_t    hold;
  byteCtx_t    cur;
  byteCtx_t    capture;
  byteCtx_t    src;
  logic        holdV;
  logic [2:0]  slot;
  logic        halfTick;

  logic        lastClk;
  logic        endOfByte;
  logic        transfer;
  logic        stepSlot;
  logic [2:0]  nSlot;
  logic        nextOn;
  logic [2:0]  nextCol;
  vdgMode_t    capMode;

  assign REQ = !holdV;

`ifdef VDG_SEMIGRAPHICS_EN
  logic semiBit;

  semi_quad_decode uSemi (
    .quad    (src.data[3:0]),
    .row     (src.row),
    .slot    (nSlot),
    .quadBit (semiBit)
  );
`else
  logic unusedSemiCtx;
  assign unusedSemiCtx = ^{src.row, src.mode};
`endif

  always_comb begin
    capMode      = decodeMode(selAlpha, selSemi);
    capture.data = DD;
    capture.row  = ROW;
    capture.css  = CSS;
    capture.mode = capMode;
    capture.div  = Divider && (capMode == MODE_GRAPH);

    lastClk   = !cur.div || halfTick;
    endOfByte = (state == ST_SHIFT) && lastClk && (slot == 3'(PIXELS_PER_BYTE - 1));
    transfer  = holdV && ((state == ST_EMPTY) || endOfByte);
    stepSlot  = (state == ST_SHIFT) && lastClk && !endOfByte;

    // Pixel for whichever slot becomes visible after this edge.
    src     = transfer ? hold : cur;
    nSlot   = transfer ? 3'd0 : slot + 3'd1;
    nextOn  = src.data[~nSlot];
    nextCol = src.css ? COL_ALT : COL_BASE;
`ifdef VDG_SEMIGRAPHICS_EN
    if (src.mode == MODE_SEMI) begin
      nextOn  = semiBit;
      nextCol = src.data[6:4];
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_EMPTY;
      hold      <= '0;
      cur       <= '0;
      holdV     <= 1'b0;
      slot      <= 3'd0;
      halfTick  <= 1'b0;
      PIX_VALID <= 1'b0;
      PIX_ON    <= 1'b0;
      PIX_COL   <= 3'd0;
      UNDERRUN  <= 1'b0;
    end else begin
      UNDERRUN <= 1'b0;

      // Transfer needs holdV=1 and a load needs holdV=0, so they never collide.
      if (transfer) begin
        holdV <= 1'b0;
      end else if (LOAD && !holdV) begin
        hold  <= capture;
        holdV <= 1'b1;
      end

      if (transfer) begin
        state     <= ST_SHIFT;
        cur       <= hold;
        slot      <= 3'd0;
        halfTick  <= 1'b0;
        PIX_VALID <= 1'b1;
        PIX_ON    <= nextOn;
        PIX_COL   <= nextCol;
      end else if (endOfByte) begin
        state     <= ST_EMPTY;
        slot      <= 3'd0;
        halfTick  <= 1'b0;
        PIX_VALID <= 1'b0;
        PIX_ON    <= 1'b0;
        PIX_COL   <= 3'd0;
        UNDERRUN  <= 1'b1;
      end else if (stepSlot) begin
        slot     <= nSlot;
        halfTick <= 1'b0;
        PIX_ON   <= nextOn;
        PIX_COL  <= nextCol;
      end else if (state == ST_SHIFT) begin
        halfTick <= 1'b1;
      end
    end
  end

endmodule
